// File: rtl/reg_file_scrub.sv
// Register file with two combinational read ports, one write port and a hardware scrub engine.
// Reads have zero latency. Writes land on the next clk edge. A clear takes DEPTH-1 edges.
// While clearing, ready=0, writes and clr_req are ignored, and reads return 0. Optional macro: REG_FILE_BYPASS_EN.
module reg_file_scrub #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic              WE3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              clr_req,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_PTR  = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;

    // Entry 0 reads as zero and is never stored.
    logic [DATA_W-1:0] mem [1:DEPTH-1];

    logic wr_user;
    assign wr_user = (state == READY) && WE3 && (A3 != '0);

    // Scrub sequencing: walk clr_ptr from 1 to DEPTH-1, then open the file. A READY-state clr_req restarts the walk.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= CLEAR;
            clr_ptr <= FIRST_PTR;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_ptr == LAST_PTR) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= FIRST_PTR;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= FIRST_PTR;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Storage update. The scrub engine owns the write port while clearing.
    // A user write that coincides with clr_req still lands; the clear that follows wipes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_user) begin
            mem[A3] <= WD3;
        end
    end

    // Read port 1: zero while clearing or at address 0; optional forwarding of the in-flight write.
    always_comb begin
        RD1 = '0;
        if (state == READY && A1 != '0) begin
            RD1 = mem[A1];
`ifdef REG_FILE_BYPASS_EN
            if (wr_user && A1 == A3) begin
                RD1 = WD3;
            end
`endif
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        RD2 = '0;
        if (state == READY && A2 != '0) begin
            RD2 = mem[A2];
`ifdef REG_FILE_BYPASS_EN
            if (wr_user && A2 == A3) begin
                RD2 = WD3;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_scrub.sv
// Bench for reg_file_scrub: table vectors, hand-written clear/reset sequences and random traffic.
// An abstract model tracks the remaining clear length as a countdown and keeps an array of contents.
// Outputs are sampled 2 time units after the falling edge, while inputs are stable.
module tb_reg_file_scrub;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

`ifdef REG_FILE_BYPASS_EN
    localparam logic [31:0] R4_E1 = 32'h1234_5678;
    localparam logic [31:0] R6_E2 = 32'hA5A5_A5A5;
`else
    localparam logic [31:0] R4_E1 = 32'h0000_0000;
    localparam logic [31:0] R6_E2 = 32'h1234_5678;
`endif

    logic          clk;
    logic          RST;
    logic [AW-1:0] A1, A2, A3;
    logic          WE3;
    logic [DW-1:0] WD3;
    logic          clr_req;
    logic [DW-1:0] RD1, RD2;
    logic          ready;

    reg_file_scrub #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .RST(RST), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3),
        .WD3(WD3), .clr_req(clr_req), .RD1(RD1), .RD2(RD2), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Abstract model: either clearing (with a count of edges left) or usable, plus the contents array.
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_clearing;
    int            m_left;

    logic [DW-1:0] last_rd1, last_rd2;
    logic          last_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_start_clear();
        m_clearing = 1'b1;
        m_left     = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a, input logic we,
                                               input logic [AW-1:0] a3, input logic [DW-1:0] wd);
        if (m_clearing || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (we && a3 != 0 && a == a3) return wd;
`endif
        return m_mem[a];
    endfunction

    // One cycle: drive at the falling edge, check mid-phase, clock, then advance the model.
    task automatic step(input logic rst_i, input logic we_i, input logic [AW-1:0] a3_i,
                        input logic [DW-1:0] wd_i, input logic [AW-1:0] a1_i,
                        input logic [AW-1:0] a2_i, input logic clr_i);
        RST = rst_i; WE3 = we_i; A3 = a3_i; WD3 = wd_i; A1 = a1_i; A2 = a2_i; clr_req = clr_i;
        if (rst_i) model_start_clear();
        #2;
        last_rd1 = RD1; last_rd2 = RD2; last_rdy = ready;
        chk("model_rd1",   RD1,   model_rd(a1_i, we_i, a3_i, wd_i));
        chk("model_rd2",   RD2,   model_rd(a2_i, we_i, a3_i, wd_i));
        chk("model_ready", {31'b0, ready}, {31'b0, ~m_clearing});
        @(posedge clk);
        if (rst_i) begin
            model_start_clear();
        end else if (m_clearing) begin
            m_left--;
            if (m_left == 0) m_clearing = 1'b0;
        end else begin
            if (we_i && a3_i != 0) m_mem[a3_i] = wd_i;
            if (clr_i) model_start_clear();
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] a1_i, input logic [AW-1:0] a2_i);
        step(1'b0, 1'b0, '0, '0, a1_i, a2_i, 1'b0);
    endtask

    // Idle cycles until ready is seen, bounded; returns the number of edges taken.
    task automatic edges_to_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            idle(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
            n++;
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] a3;
        logic [DW-1:0] wd;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    vec_t tbl [8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        logic [DW-1:0] d;

        tbl[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0};
        tbl[2] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF};
        tbl[3] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 32'h0, 32'h0};
        tbl[4] = '{1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd5, R4_E1, 32'hDEAD_BEEF};
        tbl[5] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678};
        tbl[6] = '{1'b1, 5'd7, 32'hA5A5_A5A5, 5'd0, 5'd7, 32'h0, R6_E2};
        tbl[7] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd0, 32'hA5A5_A5A5, 32'h0};

        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_clearing = 1'b1; m_left = DEPTH - 1;
        RST = 1'b1; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0; clr_req = 1'b0;
        @(negedge clk);

        // Reset state: held in clear with reads forced to zero.
        step(1'b1, 1'b1, 5'd3, 32'h1111_1111, 5'd3, 5'd4, 1'b0);
        chk("reset_ready", {31'b0, last_rdy}, 32'd0);
        chk("reset_rd1", last_rd1, 32'h0);
        step(1'b1, 1'b0, '0, '0, 5'd1, 5'd31, 1'b0);

        // Clear after reset takes exactly DEPTH-1 edges, then the whole file reads zero.
        edges_to_ready(n);
        chk("reset_clear_edges", n, 32'd31);
        for (int i = 1; i < DEPTH; i++) begin
            idle(AW'(i), AW'(DEPTH - i));
            chk("post_reset_zero", last_rd1 | last_rd2, 32'h0);
        end

        // Directed vectors: basic write/read, address-0 writes, same-cycle write/read.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, tbl[i].we, tbl[i].a3, tbl[i].wd, tbl[i].a1, tbl[i].a2, 1'b0);
            chk($sformatf("tbl%0d_rd1", i), last_rd1, tbl[i].e1);
            chk($sformatf("tbl%0d_rd2", i), last_rd2, tbl[i].e2);
            chk($sformatf("tbl%0d_ready", i), {31'b0, last_rdy}, 32'd1);
        end

        // Fill every entry with nonzero data, then confirm each entry holds it.
        for (int i = 1; i < DEPTH; i++)
            step(1'b0, 1'b1, AW'(i), 32'h0101_0101 * i + 32'h8000_0000, 5'd0, 5'd0, 1'b0);
        for (int i = 1; i < DEPTH; i++) begin
            idle(AW'(i), AW'(i));
            chk("fill_readback", last_rd1, 32'h0101_0101 * i + 32'h8000_0000);
        end

        // A clr_req cycle that also writes: the write still lands but is scrubbed. ready drops on the next cycle.
        step(1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd4, 5'd0, 1'b1);
        chk("clr_req_cycle_ready", {31'b0, last_rdy}, 32'd1);
        step(1'b0, 1'b1, 5'd10, 32'h7777_7777, 5'd10, 5'd9, 1'b1);
        chk("clear_started_ready", {31'b0, last_rdy}, 32'd0);
        n = 1;
        while (ready !== 1'b1 && n < 100) begin
            step(1'b0, 1'b1, AW'($urandom_range(1, 31)), $urandom, AW'($urandom_range(0, 31)),
                 AW'($urandom_range(0, 31)), 1'b1);
            n++;
        end
        chk("clr_req_clear_edges", n, 32'd31);
        for (int i = 1; i < DEPTH; i++) begin
            idle(AW'(i), AW'(DEPTH - i));
            chk("post_clear_zero", last_rd1 | last_rd2, 32'h0);
        end

        // Reset in the middle of a clear (pointer at entry 10) restarts the full sequence.
        step(1'b0, 1'b1, 5'd12, 32'h5555_AAAA, 5'd0, 5'd0, 1'b1);
        for (int i = 0; i < 9; i++) idle(5'd12, 5'd1);
        step(1'b1, 1'b0, '0, '0, 5'd12, 5'd12, 1'b0);
        chk("midclear_reset_ready", {31'b0, last_rdy}, 32'd0);
        edges_to_ready(n);
        chk("midclear_reset_edges", n, 32'd31);
        idle(5'd12, 5'd0);
        chk("midclear_reset_rd1", last_rd1, 32'h0);

        // Random traffic checked against the model, with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            d = $urandom;
            step(($urandom_range(0, 149) == 0), $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 31)), d, AW'($urandom_range(0, 31)),
                 AW'($urandom_range(0, 31)), ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
